// File: rtl/mic_peak_meter_if.sv
// Sample/peak bundle between the slowclk/mic capture side and mic_peak_meter.
// master drives the strobe and sample; slave is the meter publishing peak results.
interface mic_peak_meter_if;
  logic        slw;
  logic [11:0] mic_in;
  logic [11:0] peak;
  logic [3:0]  level;
  logic [15:0] led;
  logic        peak_valid;

  modport master (
    output slw, mic_in,
    input  peak, level, led, peak_valid
  );

  modport slave (
    input  slw, mic_in,
    output peak, level, led, peak_valid
  );
endinterface

// File: rtl/mic_peak_meter.sv
// Windowed microphone peak meter: max of WINDOW samples taken on slw rising edges,
// published as peak, 4-bit level and 16-LED bar. Optional feature macro: MIC_PEAK_AVG_EN.
module mic_peak_meter #(
  parameter int WINDOW = 4000,
  parameter int BASE   = 2048,
  parameter int SHIFT  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  mic_peak_meter_if.slave  bus
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [11:0]      BASE_12  = 12'(BASE);

  typedef enum logic {ACQ, PUB} state_t;

  state_t           state_reg;
  logic             slw_d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [11:0]      cur_max_reg;
  logic [11:0]      max_reg;
  logic [11:0]      peak_reg;
  logic [3:0]       level_reg;
  logic [15:0]      led_reg;
  logic             peak_valid_reg;

  logic             tick;
  logic [11:0]      new_max;
  logic [11:0]      pub_peak;
  logic             above;
  logic [11:0]      diff;
  logic [11:0]      shifted;
  logic [3:0]       level_next;
  logic [15:0]      led_next;

  // slw_d resets high so a strobe already high at reset release is not a tick
  assign tick    = bus.slw & ~slw_d_reg;
  assign new_max = (bus.mic_in > cur_max_reg) ? bus.mic_in : cur_max_reg;

`ifdef MIC_PEAK_AVG_EN
  logic [11:0] prev_max_reg;
  logic [12:0] avg_sum;
  assign avg_sum  = {1'b0, max_reg} + {1'b0, prev_max_reg};
  assign pub_peak = avg_sum[12:1];
`else
  assign pub_peak = max_reg;
`endif

  assign above      = pub_peak > BASE_12;
  assign diff       = above ? (pub_peak - BASE_12) : 12'd0;
  assign shifted    = diff >> SHIFT;
  assign level_next = (shifted > 12'd15) ? 4'd15 : shifted[3:0];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_led
      assign led_next[gi] = above && (4'(gi) <= level_next);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ACQ;
      slw_d_reg      <= 1'b1;
      cnt_reg        <= '0;
      cur_max_reg    <= '0;
      max_reg        <= '0;
      peak_reg       <= '0;
      level_reg      <= '0;
      led_reg        <= '0;
      peak_valid_reg <= 1'b0;
`ifdef MIC_PEAK_AVG_EN
      prev_max_reg   <= '0;
`endif
    end else begin
      slw_d_reg <= bus.slw;
      case (state_reg)
        ACQ: begin
          peak_valid_reg <= 1'b0;
          if (tick) begin
            if (cnt_reg == CNT_LAST) begin
              max_reg     <= new_max;
              cur_max_reg <= '0;
              cnt_reg     <= '0;
              state_reg   <= PUB;
            end else begin
              cur_max_reg <= new_max;
              cnt_reg     <= cnt_reg + 1'b1;
            end
          end
        end
        PUB: begin
          peak_reg       <= pub_peak;
          level_reg      <= level_next;
          led_reg        <= led_next;
          peak_valid_reg <= 1'b1;
`ifdef MIC_PEAK_AVG_EN
          prev_max_reg   <= max_reg;
`endif
          state_reg      <= ACQ;
          // A tick here cannot be the last of a window (cnt was just cleared)
          if (tick) begin
            cur_max_reg <= new_max;
            cnt_reg     <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ACQ;
      endcase
    end
  end

  assign bus.peak       = peak_reg;
  assign bus.level      = level_reg;
  assign bus.led        = led_reg;
  assign bus.peak_valid = peak_valid_reg;

endmodule
